// File: rtl/det_event_fifo_if.sv
// rtl/det_event_fifo_if.sv - first-word-fall-through read port of the detection event FIFO
interface det_event_fifo_if #(
    parameter int TS_W = 16
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/det_event_fifo.sv
// rtl/det_event_fifo.sv - timestamps pattern detections on bit strobes into a FWFT FIFO
module det_event_fifo #(
    parameter  int DEPTH = 4,
    parameter  int TS_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             detected,
    input  logic             clear,
    det_event_fifo_if.master rd,
    output logic [CW-1:0]    fifo_count,
    output logic [TS_W-1:0]  total_count,
    output logic             overflow
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] total_q, total_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0] mem_q [DEPTH];

    logic push, pop, full, wr_en;

    always_comb begin
        push  = bit_en & detected;
        pop   = (count_q != '0) & rd.rd_ready;
        full  = (count_q == CW'(DEPTH));
        // A pop frees the slot this cycle, so a full FIFO still accepts the push.
        wr_en = push & (~full | pop);

        ts_d     = ts_q;
        total_d  = total_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (clear) begin
            ts_d     = '0;
            total_d  = '0;
            ovf_d    = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (bit_en) ts_d = ts_q + 1'b1;
            if (push && (total_q != '1)) total_d = total_q + 1'b1;
            if (push && full && !pop) ovf_d = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(wr_en);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q     <= '0;
            total_q  <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            ts_q     <= ts_d;
            total_q  <= total_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem_q[wr_ptr_q] <= ts_q;
    end

    assign rd.rd_valid = (count_q != '0);
    assign rd.rd_data  = mem_q[rd_ptr_q];
    assign fifo_count  = count_q;
    assign total_count = total_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/det_event_fifo.md
DET_EVENT_FIFO -- requirements
Module: det_event_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TS_W, default 16, timestamp and total-counter width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion SHALL force reset state immediately, deassertion SHALL be synchronous to clk.
REQ-005 bit_en  input  1  one-cycle strobe marking each slowed bit period in which detected is valid.
REQ-006 detected  input  1  Mealy pattern-detect output from the upstream detector; sampled only when bit_en=1.
REQ-007 clear  input  1  synchronous clear of FIFO, counters and flags.
REQ-008 rd_ready  input  1  consumer accepts head entry.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 rd_data  output  TS_W  timestamp of head entry.
REQ-011 fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 total_count  output  TS_W  detections seen since reset/clear, saturating.
REQ-013 overflow  output  1  sticky flag: at least one detection dropped.

Function
REQ-014 Timestamp counter ts (TS_W bits) SHALL increment by 1 on every cycle with bit_en=1, wrapping from all-ones to 0.
REQ-015 Event SHALL be captured only when bit_en=1 and detected=1 in the same cycle; detected with bit_en=0 SHALL be ignored.
REQ-016 Captured entry value SHALL be ts before that cycle's increment.
REQ-017 total_count SHALL increment by 1 per captured event, saturating at all-ones with no wrap; increments even if the entry is dropped.
REQ-018 FIFO SHALL be first-word fall-through: rd_valid = (fifo_count != 0); rd_data = oldest entry whenever rd_valid=1.
REQ-019 Pop SHALL occur when rd_valid=1 and rd_ready=1; rd_ready with FIFO empty SHALL have no effect.
REQ-020 Push while not full SHALL write entry and increment fifo_count; entry visible on rd_data the next cycle when previously empty.
REQ-021 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when full (no drop, no overflow) and excluding when empty (push only).
REQ-022 Push when full without pop SHALL drop the new entry, keep contents unchanged, and set overflow=1.
REQ-023 overflow SHALL remain 1 until clear or reset.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 clear=1 SHALL empty FIFO, zero ts, total_count, overflow next edge; clear SHALL take precedence over simultaneous push, pop and ts increment.
REQ-026 rd_data SHALL be don't-care while rd_valid=0; bench SHALL not check it.
REQ-027 No combinational path from detected or bit_en to any output; rd_valid and rd_data SHALL depend only on registered state.

Reset
REQ-028 While reset=0: rd_valid=0, fifo_count=0, total_count=0, overflow=0, ts=0, pointers=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clk edge.
REQ-030 FIFO storage contents need not be reset.

Verification
REQ-031 Reset release, bit_en every 4th cycle, detected=1 on the 3rd and 7th strobes, rd_ready=0 -> fifo_count=2, rd_data=2 then (after one pop) 6, total_count=2.
REQ-032 DEPTH=4, 6 captures with rd_ready=0 -> fifo_count=4, entries hold the first 4 timestamps, overflow=1, total_count=6.
REQ-033 Full FIFO, capture and pop in the same cycle -> fifo_count stays 4, overflow stays 0, oldest entry replaced by next in order.
REQ-034 detected=1 with bit_en=0 for 10 cycles -> no capture, total_count=0, ts unchanged.
REQ-035 clear with a simultaneous capture on a 3-entry FIFO -> next cycle fifo_count=0, rd_valid=0, total_count=0, ts=0, overflow=0.
REQ-036 ts preset near wrap via 2^TS_W-1 strobes, capture on the next two strobes -> entries 2^TS_W-1 then 0; reset=0 pulse mid-cycle -> rd_valid=0 asynchronously.
